// File: rtl/cmul_pp_gen.sv
// Complex partial-product generator: one shared signed DW x DW multiplier computes
// ac, bd, bc, ad over four cycles, then strobes en/shift for the downstream adder.
module cmul_pp_gen #(
    parameter int DW = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        ar,
    input  logic [DW-1:0]        ai,
    input  logic [DW-1:0]        br,
    input  logic [DW-1:0]        bi,
    input  logic                 shift_in,
    output logic [38:0]          out1,
    output logic [38:0]          out2,
    output logic [38:0]          out3,
    output logic [38:0]          out4,
    output logic                 en,
    output logic                 shift,
    output logic                 busy,
    output logic [2:0]           dbg_state_o
);

    localparam int OW = 39;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_P1    = 3'd1;
    localparam logic [2:0] S_P2    = 3'd2;
    localparam logic [2:0] S_P3    = 3'd3;
    localparam logic [2:0] S_P4    = 3'd4;
    localparam logic [2:0] S_ISSUE = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] ar_q, ai_q, br_q, bi_q;
    logic          shift_in_q;
    logic [OW-1:0] out1_q, out2_q, out3_q, out4_q;
    logic          en_q, shift_q;

    logic                   accept;
    logic signed [DW-1:0]   mul_a, mul_b;
    logic signed [2*DW-1:0] prod;
    logic signed [OW-1:0]   prod_ext;

    // Handshake: a pair transfers on any rising edge where in_valid && in_ready;
    // in_ready depends only on state and clr, never on in_valid.
    assign in_ready = ((state_q == S_IDLE) || (state_q == S_ISSUE)) && !clr;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = accept ? S_P1 : S_IDLE;
                S_P1:    state_d = S_P2;
                S_P2:    state_d = S_P3;
                S_P3:    state_d = S_P4;
                S_P4:    state_d = S_ISSUE;
                S_ISSUE: state_d = accept ? S_P1 : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mul_a = ar_q;
        mul_b = br_q;
        case (state_q)
            S_P2:    begin mul_a = ai_q; mul_b = bi_q; end
            S_P3:    begin mul_a = ai_q; mul_b = br_q; end
            S_P4:    begin mul_a = ar_q; mul_b = bi_q; end
            default: begin mul_a = ar_q; mul_b = br_q; end
        endcase
    end

    // Full-precision product; (-2^(DW-1))^2 fits because the result is 2*DW bits wide.
    assign prod     = mul_a * mul_b;
    assign prod_ext = OW'(prod);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ar_q       <= '0;
            ai_q       <= '0;
            br_q       <= '0;
            bi_q       <= '0;
            shift_in_q <= 1'b0;
            out1_q     <= '0;
            out2_q     <= '0;
            out3_q     <= '0;
            out4_q     <= '0;
            en_q       <= 1'b0;
            shift_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ar_q       <= ar;
                ai_q       <= ai;
                br_q       <= br;
                bi_q       <= bi;
                shift_in_q <= shift_in;
            end
            if (!clr) begin
                if (state_q == S_P1) out1_q <= prod_ext;
                if (state_q == S_P2) out2_q <= prod_ext;
                if (state_q == S_P3) out3_q <= prod_ext;
                if (state_q == S_P4) out4_q <= prod_ext;
            end
            en_q    <= (state_d == S_ISSUE);
            shift_q <= (state_d == S_ISSUE) && shift_in_q;
        end
    end

    assign out1        = out1_q;
    assign out2        = out2_q;
    assign out3        = out3_q;
    assign out4        = out4_q;
    assign en          = en_q;
    assign shift       = shift_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cmul_pp_gen.sv
// Directed bench for cmul_pp_gen: latency, product values, back-to-back, reset and clr abort.
module tb_cmul_pp_gen;

    localparam int DW = 19;

    logic          clk;
    logic          reset;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] ar, ai, br, bi;
    logic          shift_in;
    logic [38:0]   out1, out2, out3, out4;
    logic          en, shift, busy;
    logic [2:0]    dbg_state;

    int checks;
    int errors;

    cmul_pp_gen #(.DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ar          (ar),
        .ai          (ai),
        .br          (br),
        .bi          (bi),
        .shift_in    (shift_in),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .out4        (out4),
        .en          (en),
        .shift       (shift),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int a_r, input int a_i, input int b_r, input int b_i, input logic sh);
        ar       = DW'(a_r);
        ai       = DW'(a_i);
        br       = DW'(b_r);
        bi       = DW'(b_i);
        shift_in = sh;
    endtask

    // Offers one pair from IDLE, then counts edges after the accept edge until en is seen.
    task automatic run_op(input int a_r, input int a_i, input int b_r, input int b_i,
                          input logic sh, output int lat);
        set_ops(a_r, a_i, b_r, b_i, sh);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (en !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; clr = 1'b0; in_valid = 1'b0;
        set_ops(0, 0, 0, 0, 1'b0);
        repeat (3) tick();
        checks++;
        if (out1 !== 39'd0 || out2 !== 39'd0 || out3 !== 39'd0 || out4 !== 39'd0 ||
            en !== 1'b0 || shift !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %h %h %h %h en=%b shift=%b busy=%b, need all zero",
                     out1, out2, out3, out4, en, shift, busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        set_ops(3, 4, 5, 6, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || en !== 1'b0) begin
            errors++;
            $display("FAIL basic_p1: busy=%b ready=%b en=%b, need 1 0 0", busy, in_ready, en);
        end
        lat = 0;
        while (en !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges need 4", lat);
        end
        checks++;
        if (out1 !== 39'd15 || out2 !== 39'd24 || out3 !== 39'd20 || out4 !== 39'd18 || shift !== 1'b0) begin
            errors++;
            $display("FAIL basic_products: got %0d %0d %0d %0d shift=%b need 15 24 20 18 0",
                     out1, out2, out3, out4, shift);
        end
        checks++;
        if (($signed(out1) - $signed(out2)) != -9 || ($signed(out3) + $signed(out4)) != 38) begin
            errors++;
            $display("FAIL basic_downstream: got outr=%0d outi=%0d need -9 38",
                     $signed(out1) - $signed(out2), $signed(out3) + $signed(out4));
        end
        tick();
        checks++;
        if (en !== 1'b0 || busy !== 1'b0 || out1 !== 39'd15 || out4 !== 39'd18) begin
            errors++;
            $display("FAIL basic_after: en=%b busy=%b out1=%0d out4=%0d need 0 0 15 18", en, busy, out1, out4);
        end
    endtask

    task automatic test_min_operands();
        int lat;
        run_op(-262144, -262144, -262144, -262144, 1'b0, lat);
        checks++;
        if (lat != 4 || out1 !== 39'h10_0000_0000 || out2 !== 39'h10_0000_0000 ||
            out3 !== 39'h10_0000_0000 || out4 !== 39'h10_0000_0000) begin
            errors++;
            $display("FAIL min_operands: lat=%0d got %h %h %h %h need 4 and 1000000000 x4",
                     lat, out1, out2, out3, out4);
        end
        tick();
    endtask

    task automatic test_signed_shift();
        int lat;
        run_op(-7, 2, 3, -5, 1'b1, lat);
        checks++;
        if (lat != 4 || out1 !== 39'h7F_FFFF_FFEB || out2 !== 39'h7F_FFFF_FFF6 ||
            out3 !== 39'd6 || out4 !== 39'd35) begin
            errors++;
            $display("FAIL signed_products: lat=%0d got %h %h %h %h need 4 7fffffffeb 7ffffffff6 6 23",
                     lat, out1, out2, out3, out4);
        end
        checks++;
        if (shift !== 1'b1) begin
            errors++;
            $display("FAIL shift_during_en: got %b need 1", shift);
        end
        tick();
        checks++;
        if (shift !== 1'b0 || en !== 1'b0) begin
            errors++;
            $display("FAIL shift_after_en: shift=%b en=%b need 0 0", shift, en);
        end
    endtask

    task automatic test_back_to_back();
        int    sets_ar[3]  = '{1, -1, 100};
        int    sets_ai[3]  = '{2, 5, -3};
        int    sets_br[3]  = '{3, 7, -50};
        int    sets_bi[3]  = '{4, -2, 9};
        longint exp_ac[3]  = '{3, -7, -5000};
        longint exp_bd[3]  = '{8, -10, -27};
        longint exp_bc[3]  = '{6, 35, 150};
        longint exp_ad[3]  = '{4, 2, 900};
        int    n_acc = 0;
        int    n_en = 0;
        int    cyc = 0;
        int    last_en = 0;
        logic  acc, en_before;
        set_ops(sets_ar[0], sets_ai[0], sets_br[0], sets_bi[0], 1'b0);
        in_valid = 1'b1;
        while (n_en < 3 && cyc < 60) begin
            acc       = in_valid && in_ready;
            en_before = en;
            tick();
            cyc++;
            if (acc) begin
                if (n_acc > 0) begin
                    checks++;
                    if (en_before !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_accept_in_issue: accept %0d with en=%b need 1", n_acc, en_before);
                    end
                end
                n_acc++;
                if (n_acc < 3) set_ops(sets_ar[n_acc], sets_ai[n_acc], sets_br[n_acc], sets_bi[n_acc], 1'b0);
                else in_valid = 1'b0;
            end
            if (en === 1'b1) begin
                checks++;
                if (out1 !== 39'(exp_ac[n_en]) || out2 !== 39'(exp_bd[n_en]) ||
                    out3 !== 39'(exp_bc[n_en]) || out4 !== 39'(exp_ad[n_en])) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %h %h %h %h need %h %h %h %h", n_en,
                             out1, out2, out3, out4, 39'(exp_ac[n_en]), 39'(exp_bd[n_en]),
                             39'(exp_bc[n_en]), 39'(exp_ad[n_en]));
                end
                if (n_en > 0) begin
                    checks++;
                    if (cyc - last_en != 5) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles need 5", cyc - last_en);
                    end
                end
                last_en = cyc;
                n_en++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_en != 3 || n_acc != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results %0d accepts need 3 3", n_en, n_acc);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int seen_en = 0;
        set_ops(3, 4, 5, 6, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (out1 !== 39'd0 || out2 !== 39'd0 || out3 !== 39'd0 || out4 !== 39'd0 ||
            en !== 1'b0 || shift !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_op: got %h %h %h %h en=%b shift=%b busy=%b ready=%b need zeros, ready 1",
                     out1, out2, out3, out4, en, shift, busy, in_ready);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (en === 1'b1 || busy === 1'b1) seen_en++;
        end
        checks++;
        if (seen_en != 0) begin
            errors++;
            $display("FAIL reset_no_en: got %0d active cycles need 0", seen_en);
        end
        run_op(2, 3, 4, 5, 1'b0, lat);
        checks++;
        if (lat != 4 || out1 !== 39'd8 || out2 !== 39'd15 || out3 !== 39'd12 || out4 !== 39'd10) begin
            errors++;
            $display("FAIL reset_recover: lat=%0d got %0d %0d %0d %0d need 4 8 15 12 10",
                     lat, out1, out2, out3, out4);
        end
        tick();
    endtask

    task automatic test_clr();
        int lat;
        set_ops(6, 7, 8, 9, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        clr      = 1'b1;
        in_valid = 1'b1;
        set_ops(-2, -3, 10, 11, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready: got %b need 0", in_ready);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || en !== 1'b0 || shift !== 1'b0 || out1 !== 39'd48 || out2 !== 39'd63 ||
            out3 !== 39'd12 || out4 !== 39'd10) begin
            errors++;
            $display("FAIL clr_abort: busy=%b en=%b shift=%b got %0d %0d %0d %0d need 0 0 0 48 63 12 10",
                     busy, en, shift, out1, out2, out3, out4);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_ready_after: got %b need 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (en !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 4 || out1 !== 39'(-20) || out2 !== 39'(-33) || out3 !== 39'(-30) ||
            out4 !== 39'(-22) || shift !== 1'b1) begin
            errors++;
            $display("FAIL clr_next_op: lat=%0d got %h %h %h %h shift=%b need 4 -20 -33 -30 -22 1",
                     lat, out1, out2, out3, out4, shift);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_min_operands();
        test_signed_shift();
        test_back_to_back();
        test_reset_mid_op();
        test_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
